// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use, redirect and memory-wait control
// with boot hold, watchdog halt and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MAX_WAIT    = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             pc_sel,
  output logic             IFWrite,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_write,
  output logic             MEMWB_bubble,
  output logic             Stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(MAX_WAIT);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_MWAIT,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, redir, mstall;
  logic stall_inc, flush_inc;

  assign lu     = MemRead_ex & (rdAddr_ex != '0) &
                  ((rdAddr_ex == rs1Addr_id) | (rdAddr_ex == rs2Addr_id));
  assign redir  = Branch | Jump;
  assign mstall = mem_req & ~mem_ready;

  always_comb begin
    PCWrite      = 1'b0;
    pc_sel       = 1'b0;
    IFWrite      = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_write  = 1'b1;
    MEMWB_bubble = 1'b0;
    Stall        = 1'b0;
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    halted_d     = halted_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        IFID_flush   = 1'b1;
        IDEX_flush   = 1'b1;
        MEMWB_bubble = 1'b1;
        boot_cnt_d   = boot_cnt_q + 1'b1;
        if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
      end
      S_RUN, S_MWAIT: begin
        if (mstall) begin
          EXMEM_write  = 1'b0;
          MEMWB_bubble = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d    = S_MWAIT;
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
          if (lu) begin
            // redirect waits: branch operands are stale behind the load
            IDEX_flush = 1'b1;
            Stall      = 1'b1;
            stall_inc  = 1'b1;
          end else if (redir) begin
            PCWrite    = 1'b1;
            pc_sel     = 1'b1;
            IFWrite    = 1'b1;
            IFID_flush = 1'b1;
            flush_inc  = 1'b1;
          end else begin
            PCWrite = 1'b1;
            IFWrite = 1'b1;
          end
        end
      end
      S_HALT: begin
        EXMEM_write = 1'b0;
      end
      default: state_d = S_HALT;
    endcase
    stall_cnt_d = (stall_inc && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1
                                                 : stall_cnt_q;
    flush_cnt_d = (flush_inc && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1
                                                 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: random and directed stimulus
// against a cycle-level reference model built from the hazard rules.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int BOOT = 4;
  localparam int MAXW = 64;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MemRead_ex = 1'b0;
  logic [4:0]    rdAddr_ex = '0;
  logic [4:0]    rs1Addr_id = '0;
  logic [4:0]    rs2Addr_id = '0;
  logic          Branch = 1'b0;
  logic          Jump = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b0;
  logic          PCWrite, pc_sel, IFWrite, IFID_flush, IDEX_flush;
  logic          EXMEM_write, MEMWB_bubble, Stall, halted;
  logic [CW-1:0] stall_count, flush_count;

  pipe_hazard_ctrl #(
    .BOOT_CYCLES(BOOT), .MAX_WAIT(MAXW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .Branch(Branch), .Jump(Jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .pc_sel(pc_sel), .IFWrite(IFWrite),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .EXMEM_write(EXMEM_write), .MEMWB_bubble(MEMWB_bubble),
    .Stall(Stall), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pcw, pcs, ifw, ifidf, idexf, exmw, memwb, stl, hlt;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model state (plain integers)
  int  m_boot_done = 0;
  int  m_wait = 0;
  bit  m_halt = 0;
  int  m_sc = 0;
  int  m_fc = 0;
  localparam int SAT = (1 << CW) - 1;

  task automatic drive(input logic rn, input logic mr,
                       input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic br,
                       input logic jp, input logic mq, input logic mrdy);
    exp_t e;
    bit   lu, rdr, mst;
    @(posedge clk);
    #1;
    rst_n = rn; MemRead_ex = mr; rdAddr_ex = rd;
    rs1Addr_id = r1; rs2Addr_id = r2; Branch = br; Jump = jp;
    mem_req = mq; mem_ready = mrdy;
    e = '0;
    e.exmw = 1'b1;
    if (!rn) begin
      m_boot_done = 0; m_wait = 0; m_halt = 0; m_sc = 0; m_fc = 0;
    end
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
    if (!rn || (!m_halt && m_boot_done < BOOT)) begin
      e.ifidf = 1; e.idexf = 1; e.memwb = 1;
      if (rn) m_boot_done++;
    end else if (m_halt) begin
      e.exmw = 0; e.hlt = 1;
    end else begin
      lu  = mr && rd != 0 && (rd == r1 || rd == r2);
      rdr = br || jp;
      mst = mq && !mrdy;
      if (mst) begin
        e.exmw = 0; e.memwb = 1;
        m_wait++;
        if (m_wait == MAXW) m_halt = 1;
      end else begin
        m_wait = 0;
        if (lu) begin
          e.stl = 1; e.idexf = 1;
          if (m_sc < SAT) m_sc++;
        end else if (rdr) begin
          e.pcw = 1; e.pcs = 1; e.ifw = 1; e.ifidf = 1;
          if (m_fc < SAT) m_fc++;
        end else begin
          e.pcw = 1; e.ifw = 1;
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {PCWrite, pc_sel, IFWrite, IFID_flush, IDEX_flush,
           EXMEM_write, MEMWB_bubble, Stall, halted,
           stall_count, flush_count};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d t=%0t: got pcw,pcs,ifw,ifidf,idexf,exmw,memwb,stl,hlt=%b sc=%0d fc=%0d, required %b sc=%0d fc=%0d",
                 n_vec, $time, a[2*CW+8:2*CW], a.sc, a.fc,
                 e[2*CW+8:2*CW], e.sc, e.fc);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not reach end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(8);
    // load-use on rs2, then the x0 destination case
    drive(1, 1, 5, 1, 5, 0, 0, 0, 0);
    idle(2);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use with branch, then branch alone
    drive(1, 1, 7, 7, 3, 1, 0, 0, 0);
    drive(1, 0, 7, 7, 3, 1, 0, 0, 0);
    idle(2);
    // freeze with jump pending, then the ready cycle
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      drive(1, $urandom_range(0, 9) < 3,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
            $urandom_range(0, 9) < 2, $urandom_range(0, 1) == 1);
    end
    // watchdog: persistent wait halts, reset recovers
    for (int i = 0; i < MAXW + 6; i++) drive(1, 1, 2, 2, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    // reset in the middle of a memory wait
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(6);
    // stall counter saturation
    for (int i = 0; i < SAT + 3; i++) drive(1, 1, 9, 9, 1, 0, 0, 0, 0);
    idle(2);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
